// File: rtl/axi_fifo_manager.sv
// AXI4-Lite manager: pops scripted commands one at a time, runs a single read or write
// per command and pushes {is_read, resp, rdata} into the response FIFO in command order.
module axi_fifo_manager #(
    parameter int unsigned AXI_ADDR_WIDTH = 16,
    parameter int unsigned AXI_DATA_WIDTH = 32
) (
    input  logic                                   aclk,
    input  logic                                   aresetn,
    input  logic [AXI_ADDR_WIDTH+AXI_DATA_WIDTH:0] cmd_rd_data,
    input  logic                                   cmd_empty,
    output logic                                   cmd_rd_en,
    output logic [AXI_DATA_WIDTH+2:0]              rsp_wr_data,
    output logic                                   rsp_wr_en,
    input  logic                                   rsp_full,
    output logic [AXI_ADDR_WIDTH-1:0]              m_axi_awaddr,
    output logic [2:0]                             m_axi_awprot,
    output logic                                   m_axi_awvalid,
    input  logic                                   m_axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]              m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]            m_axi_wstrb,
    output logic                                   m_axi_wvalid,
    input  logic                                   m_axi_wready,
    input  logic [1:0]                             m_axi_bresp,
    input  logic                                   m_axi_bvalid,
    output logic                                   m_axi_bready,
    output logic [AXI_ADDR_WIDTH-1:0]              m_axi_araddr,
    output logic [2:0]                             m_axi_arprot,
    output logic                                   m_axi_arvalid,
    input  logic                                   m_axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0]              m_axi_rdata,
    input  logic [1:0]                             m_axi_rresp,
    input  logic                                   m_axi_rvalid,
    output logic                                   m_axi_rready,
    output logic                                   busy,
    output logic [15:0]                            err_count
);

    localparam int unsigned A      = AXI_ADDR_WIDTH;
    localparam int unsigned D      = AXI_DATA_WIDTH;
    localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
    localparam int unsigned ERR_W  = 16;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WAIT_B  = 3'd2,
        RD_ADDR = 3'd3,
        WAIT_R  = 3'd4,
        PUSH    = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic             awvalid_q, awvalid_d;
    logic             wvalid_q, wvalid_d;
    logic             arvalid_q, arvalid_d;
    logic [A-1:0]     awaddr_q, awaddr_d;
    logic [A-1:0]     araddr_q, araddr_d;
    logic [D-1:0]     wdata_q, wdata_d;
    logic [D-1:0]     rdata_q, rdata_d;
    logic             is_read_q, is_read_d;
    logic [1:0]       resp_q, resp_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             busy_q;
    logic             pop_c, push_c;
    logic             aw_done_c, w_done_c;

    logic             cmd_is_read;
    logic [A-1:0]     cmd_addr;
    logic [D-1:0]     cmd_wdata;

    assign cmd_is_read = cmd_rd_data[A+D];
    assign cmd_addr    = cmd_rd_data[A+D-1:D];
    assign cmd_wdata   = cmd_rd_data[D-1:0];

    // Address/data phase of a write completes once each channel has handshaken (in any order).
    assign aw_done_c = !awvalid_q || m_axi_awready;
    assign w_done_c  = !wvalid_q  || m_axi_wready;

    // Next-state and next-register-value decode.
    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        awaddr_d  = awaddr_q;
        araddr_d  = araddr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        is_read_d = is_read_q;
        resp_d    = resp_q;
        err_d     = err_q;
        pop_c     = 1'b0;
        push_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!cmd_empty) begin
                    pop_c     = 1'b1;
                    is_read_d = cmd_is_read;
                    resp_d    = 2'b00;
                    rdata_d   = '0;
                    if (cmd_is_read) begin
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = RD_ADDR;
                    end else begin
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_ADDR;
                    end
                end
            end
            WR_ADDR: begin
                if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
                if (aw_done_c && w_done_c)      state_d   = WAIT_B;
            end
            WAIT_B: begin
                if (m_axi_bvalid) begin
                    resp_d  = m_axi_bresp;
                    state_d = PUSH;
                end
            end
            RD_ADDR: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = WAIT_R;
                end
            end
            WAIT_R: begin
                if (m_axi_rvalid) begin
                    rdata_d = m_axi_rdata;
                    resp_d  = m_axi_rresp;
                    state_d = PUSH;
                end
            end
            PUSH: begin
                if (!rsp_full) begin
                    push_c  = 1'b1;
                    state_d = IDLE;
                    if (resp_q != 2'b00 && err_q != ERR_MAX) err_d = err_q + ERR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            is_read_q <= 1'b0;
            resp_q    <= 2'b00;
            err_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            awaddr_q  <= awaddr_d;
            araddr_q  <= araddr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            is_read_q <= is_read_d;
            resp_q    <= resp_d;
            err_q     <= err_d;
            busy_q    <= (state_d != IDLE);
        end
    end

    // FIFO strobes are gated by reset so nothing is popped or pushed while it is held.
    assign cmd_rd_en     = pop_c && aresetn;
    assign rsp_wr_en     = push_c && aresetn;
    assign rsp_wr_data   = {is_read_q, resp_q, rdata_q};

    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = {STRB_W{1'b1}};
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = (state_q == WAIT_B);
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = (state_q == WAIT_R);
    assign busy          = busy_q;
    assign err_count     = err_q;

endmodule

// File: tb/tb_axi_fifo_manager.sv
// Directed bench for axi_fifo_manager: FWFT command queue, response capture and a
// configurable AXI4-Lite subordinate with per-channel ready delays.
module tb_axi_fifo_manager;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [48:0] cmd_rd_data = '0;
    logic        cmd_empty = 1'b1;
    logic        cmd_rd_en;
    logic [34:0] rsp_wr_data;
    logic        rsp_wr_en;
    logic        rsp_full = 1'b0;
    logic [15:0] m_axi_awaddr;
    logic [2:0]  m_axi_awprot;
    logic        m_axi_awvalid;
    logic        m_axi_awready = 1'b0;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready = 1'b0;
    logic [1:0]  m_axi_bresp = 2'b00;
    logic        m_axi_bvalid = 1'b0;
    logic        m_axi_bready;
    logic [15:0] m_axi_araddr;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_arvalid;
    logic        m_axi_arready = 1'b0;
    logic [31:0] m_axi_rdata = '0;
    logic [1:0]  m_axi_rresp = 2'b00;
    logic        m_axi_rvalid = 1'b0;
    logic        m_axi_rready;
    logic        busy;
    logic [15:0] err_count;

    int errors = 0;
    int checks = 0;

    // subordinate configuration
    int          aw_delay = 0;
    int          w_delay = 0;
    logic [1:0]  cfg_bresp = 2'b00;
    logic [1:0]  cfg_rresp = 2'b00;
    logic [31:0] cfg_rdata = '0;
    bit          r_stall = 1'b0;

    // monitor-owned observations
    int          cyc = 0;
    int          aw_hs_cnt = 0, w_hs_cnt = 0, b_hs_cnt = 0, ar_hs_cnt = 0, r_hs_cnt = 0;
    int          awv_cnt = 0, wv_cnt = 0, rr_cnt = 0;
    int          pop_cnt = 0, push_cnt = 0;
    int          aw_cyc = 0, w_cyc = 0, b_cyc = 0, ar_cyc = 0, r_cyc = 0, pop_cyc = 0;
    logic [15:0] aw_seen = '0, ar_seen = '0;
    logic [31:0] w_seen = '0;
    int          pop_cycs[$];
    int          push_cycs[$];
    logic [34:0] rsp_q[$];

    // driver-owned state
    logic [48:0] cmdq[$];
    int          pops_done = 0;
    int          aw_cnt = 0, w_cnt = 0;
    int          b_issued = 0, r_issued = 0;

    axi_fifo_manager #(.AXI_ADDR_WIDTH(16), .AXI_DATA_WIDTH(32)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_rd_data(cmd_rd_data), .cmd_empty(cmd_empty), .cmd_rd_en(cmd_rd_en),
        .rsp_wr_data(rsp_wr_data), .rsp_wr_en(rsp_wr_en), .rsp_full(rsp_full),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .busy(busy), .err_count(err_count)
    );

    always #5 aclk = ~aclk;

    // Record handshakes and FIFO strobes as sampled on the active edge.
    always @(posedge aclk) begin
        cyc++;
        if (!aresetn) begin
            aw_hs_cnt = 0; w_hs_cnt = 0; b_hs_cnt = 0; ar_hs_cnt = 0; r_hs_cnt = 0;
        end else begin
            if (m_axi_awvalid) awv_cnt++;
            if (m_axi_wvalid)  wv_cnt++;
            if (m_axi_rready)  rr_cnt++;
            if (m_axi_awvalid && m_axi_awready) begin aw_hs_cnt++; aw_cyc = cyc; aw_seen = m_axi_awaddr; end
            if (m_axi_wvalid && m_axi_wready)   begin w_hs_cnt++;  w_cyc = cyc;  w_seen = m_axi_wdata; end
            if (m_axi_bvalid && m_axi_bready)   begin b_hs_cnt++;  b_cyc = cyc; end
            if (m_axi_arvalid && m_axi_arready) begin ar_hs_cnt++; ar_cyc = cyc; ar_seen = m_axi_araddr; end
            if (m_axi_rvalid && m_axi_rready)   begin r_hs_cnt++;  r_cyc = cyc; end
            if (cmd_rd_en) begin pop_cnt++; pop_cyc = cyc; pop_cycs.push_back(cyc); end
            if (rsp_wr_en) begin push_cnt++; push_cycs.push_back(cyc); rsp_q.push_back(rsp_wr_data); end
        end
    end

    // Drive the command FIFO and the subordinate away from the active edge.
    always @(negedge aclk) begin
        while (pops_done < pop_cnt) begin
            if (cmdq.size() > 0) void'(cmdq.pop_front());
            pops_done++;
        end
        cmd_empty   = (cmdq.size() == 0);
        cmd_rd_data = (cmdq.size() == 0) ? 49'h0 : cmdq[0];
        if (!aresetn) begin
            m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
            m_axi_bvalid = 1'b0;  m_axi_rvalid = 1'b0;
            aw_cnt = 0; w_cnt = 0; b_issued = 0; r_issued = 0;
        end else begin
            if (m_axi_bvalid && b_hs_cnt == b_issued) m_axi_bvalid = 1'b0;
            if (m_axi_rvalid && r_hs_cnt == r_issued) m_axi_rvalid = 1'b0;
            m_axi_awready = m_axi_awvalid && (aw_cnt >= aw_delay);
            if (m_axi_awvalid) aw_cnt++; else aw_cnt = 0;
            m_axi_wready = m_axi_wvalid && (w_cnt >= w_delay);
            if (m_axi_wvalid) w_cnt++; else w_cnt = 0;
            m_axi_arready = m_axi_arvalid;
            if (!m_axi_bvalid && aw_hs_cnt > b_issued && w_hs_cnt > b_issued) begin
                m_axi_bvalid = 1'b1; m_axi_bresp = cfg_bresp; b_issued++;
            end
            if (!m_axi_rvalid && !r_stall && ar_hs_cnt > r_issued) begin
                m_axi_rvalid = 1'b1; m_axi_rresp = cfg_rresp; m_axi_rdata = cfg_rdata; r_issued++;
            end
        end
    end

    // Bounded wait for n responses and an idle block.
    task automatic wait_rsp(input int n, input string name);
        int k;
        k = 0;
        while ((rsp_q.size() < n || busy !== 1'b0) && k < 200) begin
            @(posedge aclk); #1; k++;
        end
        checks++;
        if (rsp_q.size() < n || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_done: responses=%0d busy=%b, required %0d responses and idle", name, rsp_q.size(), busy, n);
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        checks++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_handshake: aw/w/ar valid, b/r ready = %b, required 00000",
                     {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready});
        end
        checks++;
        if ({cmd_rd_en, rsp_wr_en, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_strobes: cmd_rd_en/rsp_wr_en/busy = %b, required 000", {cmd_rd_en, rsp_wr_en, busy});
        end
        checks++;
        if (err_count !== 16'h0 || rsp_wr_data !== 35'h0 || m_axi_awaddr !== 16'h0 ||
            m_axi_araddr !== 16'h0 || m_axi_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: err=%h rsp=%h awaddr=%h araddr=%h wdata=%h, required all zero",
                     err_count, rsp_wr_data, m_axi_awaddr, m_axi_araddr, m_axi_wdata);
        end
        checks++;
        if (m_axi_wstrb !== 4'hF || m_axi_awprot !== 3'b000 || m_axi_arprot !== 3'b000) begin
            errors++;
            $display("FAIL reset_ties: wstrb=%h awprot=%b arprot=%b, required f 000 000",
                     m_axi_wstrb, m_axi_awprot, m_axi_arprot);
        end
        aresetn = 1'b1;
        @(posedge aclk); #1;
    endtask

    task automatic test_write();
        rsp_q.delete();
        aw_delay = 0; w_delay = 0; cfg_bresp = 2'b00;
        cmdq.push_back({1'b0, 16'h0010, 32'h0000_00A5});
        wait_rsp(1, "write");
        checks++;
        if (aw_cyc - pop_cyc != 1 || aw_seen !== 16'h0010) begin
            errors++;
            $display("FAIL write_aw: hs at +%0d addr %h, required +1 addr 0010", aw_cyc - pop_cyc, aw_seen);
        end
        checks++;
        if (w_cyc - pop_cyc != 1 || w_seen !== 32'h0000_00A5) begin
            errors++;
            $display("FAIL write_w: hs at +%0d data %h, required +1 data 000000a5", w_cyc - pop_cyc, w_seen);
        end
        checks++;
        if (b_cyc - pop_cyc != 2 || push_cycs[$] - pop_cyc != 3) begin
            errors++;
            $display("FAIL write_latency: b at +%0d push at +%0d, required +2 and +3", b_cyc - pop_cyc, push_cycs[$] - pop_cyc);
        end
        checks++;
        if (rsp_q.size() != 1 || rsp_q[0] !== 35'h0 || err_count !== 16'h0) begin
            errors++;
            $display("FAIL write_rsp: n=%0d word=%h err=%0d, required 1 word 000000000 err 0",
                     rsp_q.size(), (rsp_q.size() > 0) ? rsp_q[0] : 35'h0, err_count);
        end
    endtask

    task automatic test_read();
        int rr0;
        rr0 = rr_cnt;
        rsp_q.delete();
        cfg_rdata = 32'hDEAD_BEEF; cfg_rresp = 2'b00;
        cmdq.push_back({1'b1, 16'h0020, 32'h0});
        wait_rsp(1, "read");
        checks++;
        if (ar_cyc - pop_cyc != 1 || ar_seen !== 16'h0020 || r_cyc - pop_cyc != 2) begin
            errors++;
            $display("FAIL read_latency: ar +%0d addr %h, r +%0d, required +1 addr 0020, +2",
                     ar_cyc - pop_cyc, ar_seen, r_cyc - pop_cyc);
        end
        checks++;
        if (rsp_q.size() != 1 || rsp_q[0] !== 35'h4_DEAD_BEEF) begin
            errors++;
            $display("FAIL read_rsp: n=%0d word=%h, required 1 word 4deadbeef",
                     rsp_q.size(), (rsp_q.size() > 0) ? rsp_q[0] : 35'h0);
        end
        checks++;
        if (rr_cnt - rr0 != 1) begin
            errors++;
            $display("FAIL read_rready: rready high %0d cycles, required 1", rr_cnt - rr0);
        end
    endtask

    task automatic test_delayed(input int awd, input int wd, input string name);
        int awv0, wv0, b0;
        awv0 = awv_cnt; wv0 = wv_cnt; b0 = b_hs_cnt;
        rsp_q.delete();
        aw_delay = awd; w_delay = wd; cfg_bresp = 2'b00;
        cmdq.push_back({1'b0, 16'h0030, 32'h1234_5678});
        wait_rsp(1, name);
        checks++;
        if (awv_cnt - awv0 != awd + 1 || aw_cyc - pop_cyc != awd + 1) begin
            errors++;
            $display("FAIL %s_awvalid: high %0d cycles hs +%0d, required %0d and +%0d",
                     name, awv_cnt - awv0, aw_cyc - pop_cyc, awd + 1, awd + 1);
        end
        checks++;
        if (wv_cnt - wv0 != wd + 1 || w_cyc - pop_cyc != wd + 1) begin
            errors++;
            $display("FAIL %s_wvalid: high %0d cycles hs +%0d, required %0d and +%0d",
                     name, wv_cnt - wv0, w_cyc - pop_cyc, wd + 1, wd + 1);
        end
        checks++;
        if (b_hs_cnt - b0 != 1 || rsp_q.size() != 1 || rsp_q[0] !== 35'h0) begin
            errors++;
            $display("FAIL %s_b: b handshakes %0d responses %0d, required 1 and 1 OKAY write",
                     name, b_hs_cnt - b0, rsp_q.size());
        end
        aw_delay = 0; w_delay = 0;
    endtask

    task automatic test_back_to_back();
        int i0;
        i0 = pop_cycs.size();
        rsp_q.delete();
        cfg_bresp = 2'b00; cfg_rresp = 2'b10; cfg_rdata = 32'h0;
        cmdq.push_back({1'b0, 16'h0100, 32'h0000_0011});
        cmdq.push_back({1'b1, 16'h0104, 32'h0});
        cmdq.push_back({1'b0, 16'h0108, 32'h0000_0033});
        wait_rsp(3, "b2b");
        checks++;
        if (rsp_q.size() != 3 || rsp_q[0] !== 35'h0 || rsp_q[1] !== 35'h6_0000_0000 || rsp_q[2] !== 35'h0) begin
            errors++;
            $display("FAIL b2b_order: n=%0d words %p, required 000000000 600000000 000000000", rsp_q.size(), rsp_q);
        end
        checks++;
        if (err_count !== 16'd1) begin
            errors++;
            $display("FAIL b2b_err_count: got %0d, required 1", err_count);
        end
        checks++;
        if (pop_cycs.size() != i0 + 3 || pop_cycs[i0+1] - pop_cycs[i0] != 4 || pop_cycs[i0+2] - pop_cycs[i0+1] != 4) begin
            errors++;
            $display("FAIL b2b_spacing: pops %0d, required 3 pops 4 cycles apart", pop_cycs.size() - i0);
        end
        checks++;
        if (w_seen !== 32'h0000_0033) begin
            errors++;
            $display("FAIL b2b_wdata: last wdata %h, required 00000033", w_seen);
        end
        cfg_rresp = 2'b00;
    endtask

    task automatic test_backpressure();
        int b0, pu0, po0, rel, k;
        b0 = b_hs_cnt; pu0 = push_cnt; po0 = pop_cnt;
        rsp_q.delete();
        rsp_full = 1'b1;
        cmdq.push_back({1'b0, 16'h0200, 32'h0000_0077});
        cmdq.push_back({1'b0, 16'h0204, 32'h0000_0088});
        k = 0;
        while (b_hs_cnt == b0 && k < 50) begin @(posedge aclk); #1; k++; end
        checks++;
        if (b_hs_cnt == b0) begin
            errors++;
            $display("FAIL bp_reach_push: no b handshake within 50 cycles");
        end
        repeat (5) @(posedge aclk);
        #1;
        checks++;
        if (push_cnt != pu0 || pop_cnt != po0 + 1 || busy !== 1'b1 || rsp_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold: pushes %0d pops %0d busy %b rsp_wr_en %b, required 0 1 1 0",
                     push_cnt - pu0, pop_cnt - po0, busy, rsp_wr_en);
        end
        rsp_full = 1'b0;
        rel = cyc;
        wait_rsp(2, "bp");
        checks++;
        if (push_cycs.size() < pu0 + 1 || push_cycs[pu0] != rel + 1) begin
            errors++;
            $display("FAIL bp_release: first push at %0d, required %0d", (push_cycs.size() > pu0) ? push_cycs[pu0] : -1, rel + 1);
        end
        checks++;
        if (rsp_q.size() != 2 || rsp_q[0] !== 35'h0 || rsp_q[1] !== 35'h0 || w_seen !== 32'h0000_0088) begin
            errors++;
            $display("FAIL bp_rsp: n=%0d last wdata %h, required 2 OKAY writes, wdata 00000088", rsp_q.size(), w_seen);
        end
    endtask

    task automatic test_reset_midflight();
        int a0, pu0, k;
        a0 = ar_hs_cnt; pu0 = push_cnt;
        rsp_q.delete();
        r_stall = 1'b1;
        cmdq.push_back({1'b1, 16'h0030, 32'h0});
        cmdq.push_back({1'b0, 16'h0040, 32'h0000_0055});
        k = 0;
        while (ar_hs_cnt == a0 && k < 50) begin @(posedge aclk); #1; k++; end
        checks++;
        if (m_axi_rready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_wait_r: rready %b busy %b, required 1 1", m_axi_rready, busy);
        end
        aresetn = 1'b0;
        @(posedge aclk); #1;
        checks++;
        if ({busy, m_axi_rready, m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, cmd_rd_en, rsp_wr_en} !== 7'b0 ||
            err_count !== 16'h0 || rsp_wr_data !== 35'h0) begin
            errors++;
            $display("FAIL rst_state: busy/rready/arv/awv/wv/pop/push = %b err %0d rsp %h, required all zero",
                     {busy, m_axi_rready, m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, cmd_rd_en, rsp_wr_en},
                     err_count, rsp_wr_data);
        end
        @(posedge aclk); #1;
        aresetn = 1'b1;
        r_stall = 1'b0;
        wait_rsp(1, "rst");
        checks++;
        if (push_cnt - pu0 != 1 || rsp_q.size() != 1 || rsp_q[0] !== 35'h0) begin
            errors++;
            $display("FAIL rst_resume: pushes %0d, required exactly 1 OKAY write response", push_cnt - pu0);
        end
        checks++;
        if (aw_seen !== 16'h0040 || w_seen !== 32'h0000_0055) begin
            errors++;
            $display("FAIL rst_resume_data: awaddr %h wdata %h, required 0040 00000055", aw_seen, w_seen);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_delayed(3, 0, "aw_delay");
        test_delayed(0, 3, "w_delay");
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/axi_fifo_manager.md
# axi_fifo_manager

AXI4-Lite manager that drains a command FIFO and issues one AXI4-Lite read or write per entry. Each transaction's result goes into a response FIFO. It sits on the PL side facing FIFO-backed AXI subordinates such as the team's AXI-to-FIFO bridge, or any register bank, so PL logic can script bus accesses without a CPU. It performs strictly one transaction at a time and never drops or reorders commands.

## Interface
Parameters:
- AXI_ADDR_WIDTH, 16, address width.
- AXI_DATA_WIDTH, 32, data width; must be 32 or 64.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset, synchronous, active-low; clock aclk.
- cmd_rd_data  in  1+AXI_ADDR_WIDTH+AXI_DATA_WIDTH  first-word-fall-through command: bit [A+D] is_read, [A+D-1:D] addr, [D-1:0] wdata.
- cmd_empty  in  1  command FIFO empty.
- cmd_rd_en  out  1  one-cycle pop of the command FIFO.
- rsp_wr_data  out  3+AXI_DATA_WIDTH  response word: {is_read, resp[1:0], rdata}. rdata is 0 for writes.
- rsp_wr_en  out  1  one-cycle push into the response FIFO.
- rsp_full  in  1  response FIFO full.
- m_axi_aw{addr,valid,ready}, m_axi_w{data,strb,valid,ready}, m_axi_b{resp,valid,ready}, m_axi_ar{addr,valid,ready}, m_axi_r{data,resp,valid,ready}: standard AXI4-Lite manager channels.
  - wstrb is all ones.
  - awprot and arprot are tied to 3'b000.
- busy  out  1  high whenever the state is not IDLE.
- err_count  out  16  saturating count of non-OKAY responses.

## Operation
- States: IDLE, WR_ADDR, WAIT_B, RD_ADDR, WAIT_R, PUSH.
- IDLE:
  - If !cmd_empty: pulse cmd_rd_en, latch addr, wdata and is_read.
  - Go to RD_ADDR if is_read, otherwise WR_ADDR.
  - awvalid/wvalid (for a write) or arvalid (for a read) are set registered on the same edge.
- WR_ADDR:
  - awvalid and wvalid are held independently. Each drops on its own handshake (valid && ready).
  - Go to WAIT_B once both handshakes are complete; they may occur in the same cycle or in either order.
  - Valids never drop before their handshake.
- WAIT_B:
  - bready = 1, decoded combinationally from the state.
  - On bvalid: latch bresp and go to PUSH.
- RD_ADDR: arvalid is held until arready, then go to WAIT_R.
- WAIT_R:
  - rready = 1.
  - On rvalid: latch rdata and rresp, go to PUSH.
- PUSH:
  - rsp_wr_data is formed from the latched fields.
  - rsp_wr_en = !rsp_full. Go to IDLE on that same cycle.
  - While rsp_full is high, remain in PUSH. This is backpressure only; no AXI activity occurs.
- err_count increments in PUSH when resp != 2'b00 and the push occurs. It saturates at 16'hFFFF.
- A command is never popped while a transaction is in flight, so the response FIFO order equals the command order.
- The block has no timeout. A subordinate that never responds stalls the block, and busy stays high.

## Timing
- Reset values:
  - All valid and ready outputs = 0.
  - awaddr, araddr, wdata, rsp_wr_data = 0.
  - cmd_rd_en = 0, rsp_wr_en = 0, busy = 0, err_count = 0.
  - State = IDLE.
- Reset asserted mid-transaction forces the reset state on the next edge. The in-flight command is lost and no response is pushed.
- With an always-ready subordinate that registers its response (bvalid/rvalid one cycle after the handshake):
  - cycle 0: cmd_rd_en.
  - cycle 1: address/data handshake.
  - cycle 2: response handshake.
  - cycle 3: rsp_wr_en.
  - cycle 4: IDLE; the next pop occurs if a command is available.
- Peak throughput is therefore one transaction per 4 cycles.
- All AXI outputs are registered except bready and rready, which are state decodes.
- cmd_rd_en and rsp_wr_en are never high in the same cycle.

## Test plan
- Write 0x0000_00A5 to addr 0x0010, subordinate always ready with OKAY:
  - awaddr = 0x0010 and wdata = 0xA5 are handshaked on cycle 1.
  - Response word {0, 2'b00, 0} is pushed on cycle 3.
  - err_count stays 0.
- Read from addr 0x0020, subordinate returns rdata 0xDEAD_BEEF with OKAY:
  - Response word {1, 2'b00, 0xDEADBEEF} is pushed.
  - rready is high only in WAIT_R.
- Write where awready is delayed by 3 cycles and wready is immediate:
  - wvalid drops after cycle 1.
  - awvalid is held until its handshake; exactly one bready handshake follows.
  - Then repeat the case with wready delayed and awready immediate.
- Three back-to-back commands W, R, W against a subordinate returning SLVERR on the read:
  - Responses are pushed in order W/OKAY, R/SLVERR (rdata 0), W/OKAY.
  - err_count = 1.
- rsp_full held for 5 cycles during PUSH:
  - No push and no cmd_rd_en during those cycles.
  - Single push on the first cycle rsp_full is low.
- aresetn asserted in WAIT_R:
  - Next cycle: all outputs are at reset values and no push occurs.
  - After release, the next command is processed normally.
